// File: rtl/alu4_issue.sv
// alu4_issue: issue/writeback controller for the 4-bit combinational ALU slice.
// It holds a 4 x 4-bit register file and accepts one instruction every three
// cycles over a valid/ready handshake. An accepted instruction moves through
// IDLE -> ISSUE -> WB. The ALU result is captured at the end of ISSUE and written
// back at the end of WB. res_valid pulses in the cycle after writeback, so an
// instruction accepted in that cycle already sees the new register value.
module alu4_issue #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [1:0]       in_rd,
  input  logic [1:0]       in_rs,
  input  logic [1:0]       in_rt,
  input  logic             ld_en,
  input  logic [1:0]       ld_addr,
  input  logic [3:0]       ld_data,
  output logic [3:0]       alu_op,
  output logic [3:0]       alu_lt,
  output logic [3:0]       alu_rt,
  input  logic [3:0]       alu_out,
  output logic             res_valid,
  output logic [1:0]       res_rd,
  output logic [3:0]       res_data,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  state_t          state;
  logic [3:0][3:0] regs;
  logic [1:0]      rd_q;

  // The controller is ready only in IDLE. This is a direct decode of the state register.
  assign in_ready = (state == IDLE);

  // Sequencer, register file, ALU operand registers, and result/retire bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      // NOTE: the register file is four small flops, not a RAM macro, and the
      // architected reset value of r0..r3 is zero, so it is cleared like any other state.
      regs      <= '0;
      rd_q      <= 2'd0;
      alu_op    <= 4'd0;
      alu_lt    <= 4'd0;
      alu_rt    <= 4'd0;
      res_valid <= 1'b0;
      res_rd    <= 2'd0;
      res_data  <= 4'd0;
      retired   <= '0;
    end else begin
      res_valid <= 1'b0;

      // NOTE: the direct load is written first. The WB writeback below goes to the
      // same array later in this block, so on an address collision the later
      // non-blocking assignment wins and the load is dropped.
      if (ld_en) begin
        regs[ld_addr] <= ld_data;
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            alu_op <= in_op;
            alu_lt <= regs[in_rs];
            alu_rt <= regs[in_rt];
            rd_q   <= in_rd;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          res_data <= alu_out;
          res_rd   <= rd_q;
          state    <= WB;
        end
        WB: begin
          regs[res_rd] <= res_data;
          res_valid    <= 1'b1;
          retired      <= retired + CNT_W'(1);
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu4_issue.sv
// tb_alu4_issue: self-checking bench for alu4_issue.
// The bench drives alu_out from a reference 4-bit ALU (0010 add, 0110 subtract, and so on).
// It keeps its own register-file model and pushes the expected {rd, data} for
// each instruction to a scoreboard when it issues that instruction. A monitor
// pops and compares one entry on every res_valid strobe.
`timescale 1ns/1ps
module tb_alu4_issue;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic [1:0] rd;
    logic [3:0] data;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [1:0]       in_rd;
  logic [1:0]       in_rs;
  logic [1:0]       in_rt;
  logic             ld_en;
  logic [1:0]       ld_addr;
  logic [3:0]       ld_data;
  logic [3:0]       alu_op;
  logic [3:0]       alu_lt;
  logic [3:0]       alu_rt;
  logic [3:0]       alu_out;
  logic             res_valid;
  logic [1:0]       res_rd;
  logic [3:0]       res_data;
  logic [CNT_W-1:0] retired;

  int         errors = 0;
  int         checks = 0;
  exp_t       sb[$];
  logic [3:0] mregs [4];
  logic [CNT_W-1:0] exp_retired;

  alu4_issue #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .alu_op    (alu_op),
    .alu_lt    (alu_lt),
    .alu_rt    (alu_rt),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_rd    (res_rd),
    .res_data  (res_data),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference combinational ALU, standing in for the real slice.
  function automatic logic [3:0] alu_ref(input logic [3:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    case (op)
      4'h0:    return a & b;
      4'h1:    return a | b;
      4'h2:    return a + b;
      4'h3:    return a ^ b;
      4'h4:    return ~a;
      4'h6:    return a - b;
      4'h7:    return (a < b) ? 4'd1 : 4'd0;
      default: return b - a;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_op, alu_lt, alu_rt);

  // Scoreboard monitor: each completion strobe must match the oldest outstanding instruction.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: res_valid with rd=%0d data=%h, none outstanding",
                 res_rd, res_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({res_rd, res_data} !== {e.rd, e.data}) begin
          errors++;
          $display("FAIL sb_result: got rd=%0d data=%h, expected rd=%0d data=%h",
                   res_rd, res_data, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    sb.delete();
    for (int i = 0; i < 4; i++) mregs[i] = 4'd0;
    exp_retired = '0;
  endtask

  task automatic apply_reset();
    // NOTE: stimulus is driven with blocking assignments 1ns after the clock
    // edge, so the DUT always samples stable values at the next edge.
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic do_load(input logic [1:0] a, input logic [3:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
    mregs[a] = d;
  endtask

  // Issue one instruction and check the full three-cycle handshake.
  // The ld_when argument selects an optional direct load:
  // 0 = no load, 1 = load in the accept cycle, 2 = load during WB.
  // When hold is set, in_valid stays high for the caller's next instruction.
  task automatic do_issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                          input logic [1:0] rt, input int ld_when, input logic [1:0] ld_a,
                          input logic [3:0] ld_d, input bit hold);
    logic [3:0] a, b, r;
    exp_t       e;
    int         n;
    n = 0;
    while (!in_ready && n < 8) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: in_ready=%b, required 1", in_ready);
    end
    a = mregs[rs]; b = mregs[rt]; r = alu_ref(op, a, b);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
    if (ld_when == 1) begin
      ld_en = 1'b1; ld_addr = ld_a; ld_data = ld_d;
    end
    e.rd = rd; e.data = r;
    sb.push_back(e);
    tick();
    ld_en = 1'b0;
    if (!hold) in_valid = 1'b0;
    if (ld_when == 1) mregs[ld_a] = ld_d;
    checks++;
    if ({in_ready, res_valid, alu_op, alu_lt, alu_rt} !== {2'b00, op, a, b}) begin
      errors++;
      $display("FAIL issue_cycle: rdy/rv/op/lt/rt=%b/%b/%h/%h/%h, required 0/0/%h/%h/%h",
               in_ready, res_valid, alu_op, alu_lt, alu_rt, op, a, b);
    end
    tick();
    checks++;
    if ({in_ready, res_valid} !== 2'b00) begin
      errors++;
      $display("FAIL wb_cycle: in_ready/res_valid=%b%b, required 00", in_ready, res_valid);
    end
    if (ld_when == 2) begin
      ld_en = 1'b1; ld_addr = ld_a; ld_data = ld_d;
      if (ld_a != rd) mregs[ld_a] = ld_d;
    end
    tick();
    ld_en = 1'b0;
    mregs[rd] = r;
    exp_retired = exp_retired + 1'b1;
    checks++;
    if ({res_valid, in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL result_strobe: res_valid/in_ready=%b%b, required 11", res_valid, in_ready);
    end
    checks++;
    if (retired !== exp_retired) begin
      errors++;
      $display("FAIL retired: got %0d, required %0d", retired, exp_retired);
    end
  endtask

  // Reads a register by issuing AND rd=rs=rt=idx, which writes the same value back.
  task automatic read_reg(input logic [1:0] idx, input logic [3:0] expv);
    checks++;
    if (mregs[idx] !== expv) begin
      errors++;
      $display("FAIL model_reg%0d: model=%h, required %h", idx, mregs[idx], expv);
    end
    do_issue(4'h0, idx, idx, idx, 0, 2'd0, 4'd0, 1'b0);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({in_ready, res_valid, alu_op, alu_lt, alu_rt, res_rd, res_data, retired} !==
        {1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 4'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_values: rdy=%b rv=%b op=%h lt=%h rt=%h rd=%0d data=%h ret=%0d",
               in_ready, res_valid, alu_op, alu_lt, alu_rt, res_rd, res_data, retired);
    end
  endtask

  task automatic test_issue_basic();
    do_load(2'd1, 4'd5);
    do_load(2'd2, 4'd3);
    do_issue(4'b0010, 2'd3, 2'd1, 2'd2, 0, 2'd0, 4'd0, 1'b0);
    tick();
    checks++;
    if ({res_valid, res_rd, res_data, retired} !== {1'b0, 2'd3, 4'd8, 8'd1}) begin
      errors++;
      $display("FAIL result_hold: rv=%b rd=%0d data=%h ret=%0d, required 0/3/8/1",
               res_valid, res_rd, res_data, retired);
    end
    read_reg(2'd3, 4'd8);
    do_issue(4'b0110, 2'd0, 2'd2, 2'd1, 0, 2'd0, 4'd0, 1'b0);
    checks++;
    if (res_data !== 4'hE) begin
      errors++;
      $display("FAIL sub_result: got %h, required e", res_data);
    end
    read_reg(2'd0, 4'hE);
  endtask

  task automatic test_back_to_back();
    // r3=8, r2=3 -> r1=b; the second instruction reads r1 the cycle after its writeback.
    do_issue(4'b0010, 2'd1, 2'd3, 2'd2, 0, 2'd0, 4'd0, 1'b1);
    do_issue(4'b0010, 2'd2, 2'd1, 2'd1, 0, 2'd0, 4'd0, 1'b0);
    checks++;
    if (res_data !== 4'h6) begin
      errors++;
      $display("FAIL raw_result: got %h, required 6", res_data);
    end
  endtask

  task automatic test_wb_load_conflict();
    do_load(2'd1, 4'd5);
    do_load(2'd2, 4'd3);
    do_issue(4'b0010, 2'd3, 2'd1, 2'd2, 2, 2'd3, 4'hF, 1'b0);
    read_reg(2'd3, 4'd8);
    do_issue(4'b0010, 2'd3, 2'd1, 2'd2, 2, 2'd2, 4'hF, 1'b0);
    read_reg(2'd2, 4'hF);
    read_reg(2'd3, 4'd8);
  endtask

  task automatic test_operand_snapshot();
    do_load(2'd1, 4'd5);
    do_issue(4'b0010, 2'd0, 2'd1, 2'd2, 1, 2'd1, 4'd9, 1'b0);
    read_reg(2'd1, 4'd9);
  endtask

  task automatic test_reset_mid_issue();
    do_load(2'd1, 4'd7);
    in_valid = 1'b1; in_op = 4'h2; in_rd = 2'd2; in_rs = 2'd1; in_rt = 2'd1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_issue: in_ready=%b, required 0", in_ready);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_model();
    checks++;
    if ({in_ready, res_valid, alu_op, alu_lt, alu_rt, res_rd, res_data, retired} !==
        {1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 4'd0, 8'd0}) begin
      errors++;
      $display("FAIL mid_reset_values: rdy=%b rv=%b op=%h lt=%h rt=%h rd=%0d data=%h ret=%0d",
               in_ready, res_valid, alu_op, alu_lt, alu_rt, res_rd, res_data, retired);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_no_strobe: res_valid=%b at cycle %0d, required 0", res_valid, i);
      end
    end
    for (int i = 0; i < 4; i++) read_reg(i[1:0], 4'd0);
  endtask

  task automatic test_retired_wrap();
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      do_issue(4'($urandom_range(15)), 2'($urandom_range(3)), 2'($urandom_range(3)),
               2'($urandom_range(3)), 0, 2'd0, 4'd0, 1'b0);
      if (i == 254) begin
        checks++;
        if (retired !== 8'd255) begin
          errors++;
          $display("FAIL retired_max: got %0d, required 255", retired);
        end
      end
    end
    checks++;
    if (retired !== 8'd0) begin
      errors++;
      $display("FAIL retired_wrap: got %0d, required 0", retired);
    end
  endtask

  initial begin
    test_reset();
    test_issue_basic();
    test_back_to_back();
    test_wb_load_conflict();
    test_operand_snapshot();
    test_reset_mid_issue();
    test_retired_wrap();
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu4_issue.md
Name: alu4_issue

Overview:
- Issue/writeback controller that sits on the driving side of the team's combinational 4-bit ALU slice.
- Holds a 4-entry x 4-bit register file and accepts instructions over a valid/ready handshake.
- Drives op and both operands to the ALU, captures the ALU result one cycle later and writes it back to the destination register.
- Reports each completed result on a one-cycle result strobe.

Parameters:
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  instruction valid
- in_ready  output  1  controller can accept an instruction
- in_op  input  4  ALU opcode, passed through unchanged
- in_rd  input  2  destination register index
- in_rs  input  2  left-operand register index
- in_rt  input  2  right-operand register index
- ld_en  input  1  direct register load strobe
- ld_addr  input  2  load register index
- ld_data  input  4  load value
- alu_op  output  4  opcode to ALU (registered)
- alu_lt  output  4  left operand to ALU (registered)
- alu_rt  output  4  right operand to ALU (registered)
- alu_out  input  4  combinational ALU result
- res_valid  output  1  one-cycle completion strobe
- res_rd  output  2  destination index of completed instruction
- res_data  output  4  result written back
- retired  output  CNT_W  count of completed instructions

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous, active-low (rst_n sampled on the clk rising edge).
  - Reset values: state=IDLE, r0..r3=0, alu_op/alu_lt/alu_rt=0, res_valid=0, res_rd=0, res_data=0, retired=0.
  - Reset mid-instruction aborts it: no writeback, no res_valid.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch alu_op=in_op, alu_lt=reg[in_rs], alu_rt=reg[in_rt], rd_q=in_rd, then go ISSUE. With no accept, stay in IDLE.
  - ISSUE: in_ready=0. alu_* are stable for this full cycle. At the end of the cycle capture res_data<=alu_out and res_rd<=rd_q, then go WB.
  - WB: in_ready=0. reg[res_rd]<=res_data, res_valid=1 for this one cycle, retired<=retired+1, then go IDLE.
- Timing:
  - Accept at edge N; res_valid is high during the cycle after edge N+2.
  - Throughput is 1 instruction per 3 cycles.
  - in_valid is ignored while in_ready=0, so the source holds the instruction until accepted.
- Output holding:
  - alu_op/alu_lt/alu_rt hold their last values outside ISSUE; they change only on accept.
  - res_data/res_rd hold after res_valid drops.
- Operand snapshot: operands are read at accept time. A ld_en to in_rs or in_rt in the same cycle is not seen; the old value is used.
- ld_en:
  - Accepted in any state; writes reg[ld_addr]<=ld_data.
  - In WB with ld_addr==res_rd, the writeback wins and the load is dropped.
  - In WB with ld_addr!=res_rd, both writes occur.
- Read-after-write: an instruction accepted the cycle after WB sees the written-back value.
- retired wraps from 2^CNT_W-1 to 0.
- Opcode handling: no opcode decode inside the block; all 16 codes are issued identically.

Test Plan:
- Reset, then ld r1=5, ld r2=3; issue op=0010 rd=3 rs=1 rt=2 with bench ALU = team 4-bit ALU -> alu_lt=5, alu_rt=3 in ISSUE; res_valid 3 cycles after accept with res_rd=3, res_data=8; r3=8; retired=1.
- Issue op=0110 rd=0 rs=2 rt=1 (r2=3, r1=5) -> res_data=0xE, r0=0xE; in_ready low for exactly 2 cycles after accept.
- Back-to-back: in_valid held high with two instructions, where the second reads the first's rd -> second accepted in the cycle after WB and sees the updated value; each result is 3 cycles apart.
- ld_en to r3 with data 0xF during WB of an instruction writing r3 with 8 -> r3=8. Repeat with ld_addr=2 -> r2=0xF and r3=8.
- ld_en to rs in the accept cycle (r1 old 5, ld 9) -> alu_lt=5; r1=9 afterwards.
- rst_n low during ISSUE -> next cycle state IDLE, all regs 0, no res_valid, retired=0. Also run 256 instructions -> retired wraps to 0.
